// File: rtl/msf_pkg.sv
// Shared types and elaboration helpers for the multi-channel switch filter.
// Contents:
//   ch_state_t  per-channel state (IDLE, HELD, REPEATING)
//   calc_div    clock cycles per debounce sample
//   cnt_width   bits needed to hold 0..max_val
//   max2        larger of two ints
//   params_ok   parameter sanity check, used at elaboration by the top level
package msf_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      HELD      = 2'd1,
      REPEATING = 2'd2
   } ch_state_t;

   function automatic int calc_div(input int clk_hz, input int sample_hz);
      return (sample_hz > 0) ? (clk_hz / sample_hz) : 0;
   endfunction

   // Never narrower than one bit, so degenerate counts still give a legal vector.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic bit params_ok(input int n_ch,
                                    input int clk_hz,
                                    input int sample_hz,
                                    input int stable_cnt,
                                    input int repeat_delay,
                                    input int repeat_rate);
      return (n_ch >= 1) && (n_ch <= 32) &&
             (calc_div(clk_hz, sample_hz) >= 2) &&
             (stable_cnt >= 1) && (repeat_delay >= 1) && (repeat_rate >= 1);
   endfunction

endpackage

// File: rtl/switch_channel.sv
// One debounced switch channel: two-flop synchroniser, debounce counter,
// hold/repeat state machine and registered level/press/release outputs.
// Ports:
//   clock          system clock
//   reset          synchronous, active-high
//   tick           single-cycle sample enable from the shared prescaler
//   raw            asynchronous raw input
//   rpt_en         auto-repeat enable, sampled on tick
//   level          debounced state
//   press          one-cycle pulse on debounced rise and on every repeat
//   release_pulse  one-cycle pulse on debounced fall ("release" is a
//                  reserved word, so the port carries a suffix)
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | debounced level is 0, waiting for a debounced rise
// HELD      | level is 1, counting REPEAT_DELAY ticks while rpt_en is 1
// REPEATING | level is 1, pressing every REPEAT_RATE ticks
module switch_channel
   import msf_pkg::*;
#(
   parameter int STABLE_CNT   = 4,
   parameter int REPEAT_DELAY = 250,
   parameter int REPEAT_RATE  = 50
) (
   input  logic clock,
   input  logic reset,
   input  logic tick,
   input  logic raw,
   input  logic rpt_en,
   output logic level,
   output logic press,
   output logic release_pulse
);

   localparam int SW = cnt_width(STABLE_CNT);
   localparam int RW = cnt_width(max2(REPEAT_DELAY, REPEAT_RATE));

   // Terminal values are one below the threshold: the threshold itself is
   // reached by the increment that fires the event, so the counter never
   // holds it.
   localparam logic [SW-1:0] STAB_LAST  = SW'(STABLE_CNT - 1);
   localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

   logic          sync_meta;
   logic          sync_s;
   logic [SW-1:0] stab_cnt;
   logic [RW-1:0] rpt_cnt;
   ch_state_t     state;
   logic          flip;

   // Debounced level toggles on this edge.
   assign flip = tick && (sync_s != level) && (stab_cnt == STAB_LAST);

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_meta     <= 1'b0;
         sync_s        <= 1'b0;
         stab_cnt      <= '0;
         rpt_cnt       <= '0;
         level         <= 1'b0;
         press         <= 1'b0;
         release_pulse <= 1'b0;
         state         <= IDLE;
      end else begin
         sync_meta     <= raw;
         sync_s        <= sync_meta;
         press         <= 1'b0;
         release_pulse <= 1'b0;

         if (tick) begin
            if (sync_s == level) begin
               stab_cnt <= '0;
            end else if (stab_cnt == STAB_LAST) begin
               stab_cnt <= '0;
               level    <= ~level;
            end else begin
               stab_cnt <= stab_cnt + 1'b1;
            end

            case (state)
               IDLE: begin
                  if (flip) begin
                     press   <= 1'b1;
                     rpt_cnt <= '0;
                     state   <= HELD;
                  end
               end
               HELD: begin
                  if (flip) begin
                     release_pulse <= 1'b1;
                     rpt_cnt       <= '0;
                     state         <= IDLE;
                  end else if (rpt_en) begin
                     if (rpt_cnt == DELAY_LAST) begin
                        press   <= 1'b1;
                        rpt_cnt <= '0;
                        state   <= REPEATING;
                     end else begin
                        rpt_cnt <= rpt_cnt + 1'b1;
                     end
                  end else begin
                     rpt_cnt <= '0;
                  end
               end
               REPEATING: begin
                  if (flip) begin
                     release_pulse <= 1'b1;
                     rpt_cnt       <= '0;
                     state         <= IDLE;
                  end else if (!rpt_en) begin
                     rpt_cnt <= '0;
                     state   <= HELD;
                  end else if (rpt_cnt == RATE_LAST) begin
                     press   <= 1'b1;
                     rpt_cnt <= '0;
                  end else begin
                     rpt_cnt <= rpt_cnt + 1'b1;
                  end
               end
               default: begin
                  rpt_cnt <= '0;
                  state   <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/multi_switch_filter.sv
// N-channel switch/button filter: shared sample prescaler plus one
// switch_channel per input. Everything runs on the single system clock;
// the prescaler only produces an enable.
// Ports:
//   clock          system clock
//   reset          synchronous, active-high
//   raw_in         asynchronous raw inputs, one per channel
//   rpt_en         per-channel auto-repeat enable
//   level          debounced state per channel
//   press          one-cycle pulse on debounced rise and on each repeat
//   release_pulse  one-cycle pulse on debounced fall
//   tick           registered sample-enable pulse, once every DIV cycles
module multi_switch_filter
   import msf_pkg::*;
#(
   parameter int N_CH         = 5,
   parameter int CLK_HZ       = 100_000_000,
   parameter int SAMPLE_HZ    = 500,
   parameter int STABLE_CNT   = 4,
   parameter int REPEAT_DELAY = 250,
   parameter int REPEAT_RATE  = 50
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [N_CH-1:0] raw_in,
   input  logic [N_CH-1:0] rpt_en,
   output logic [N_CH-1:0] level,
   output logic [N_CH-1:0] press,
   output logic [N_CH-1:0] release_pulse,
   output logic            tick
);

   localparam int DIV = calc_div(CLK_HZ, SAMPLE_HZ);
   localparam int PW  = cnt_width(DIV - 1);
   localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

   if (!params_ok(N_CH, CLK_HZ, SAMPLE_HZ, STABLE_CNT, REPEAT_DELAY, REPEAT_RATE)) begin : g_param_check
      $error("multi_switch_filter: illegal parameter set");
   end

   logic [PW-1:0] pre_cnt;

   // tick is registered off the terminal count, so the first one shows up
   // DIV cycles after reset is released.
   always_ff @(posedge clock) begin
      if (reset) begin
         pre_cnt <= '0;
         tick    <= 1'b0;
      end else begin
         tick    <= (pre_cnt == PRE_LAST);
         pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      switch_channel #(
         .STABLE_CNT   (STABLE_CNT),
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_RATE  (REPEAT_RATE)
      ) u_ch (
         .clock         (clock),
         .reset         (reset),
         .tick          (tick),
         .raw           (raw_in[i]),
         .rpt_en        (rpt_en[i]),
         .level         (level[i]),
         .press         (press[i]),
         .release_pulse (release_pulse[i])
      );
   end

endmodule

// File: tb/tb_multi_switch_filter.sv
module tb_multi_switch_filter;

   localparam int N_CH      = 3;
   localparam int CLK_HZ    = 1000;
   localparam int SAMPLE_HZ = 100;
   localparam int DIV       = 10;
   localparam int STABLE    = 4;
   localparam int RDELAY    = 8;
   localparam int RRATE     = 3;

   logic            clock  = 1'b0;
   logic            reset  = 1'b1;
   logic [N_CH-1:0] raw_in = '0;
   logic [N_CH-1:0] rpt_en = '0;
   logic [N_CH-1:0] level;
   logic [N_CH-1:0] press;
   logic [N_CH-1:0] release_pulse;
   logic            tick;

   int n_checks = 0;
   int n_fail   = 0;

   multi_switch_filter #(
      .N_CH         (N_CH),
      .CLK_HZ       (CLK_HZ),
      .SAMPLE_HZ    (SAMPLE_HZ),
      .STABLE_CNT   (STABLE),
      .REPEAT_DELAY (RDELAY),
      .REPEAT_RATE  (RRATE)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .raw_in        (raw_in),
      .rpt_en        (rpt_en),
      .level         (level),
      .press         (press),
      .release_pulse (release_pulse),
      .tick          (tick)
   );

   always #5 clock = ~clock;

   // Reference model: cycle count since reset gives the tick, the raw input
   // delayed by two clocks is the sample, a run length of disagreeing samples
   // flips the level, and the number of consecutive enabled ticks spent held
   // decides repeat presses (first at RDELAY, then every RRATE).
   logic [N_CH-1:0] m_level, m_press, m_rel, m_d1, m_d2;
   logic            m_tick;
   int              m_cyc;
   int              m_run  [N_CH];
   int              m_held [N_CH];

   initial begin
      forever begin
         logic [N_CH-1:0] samp;
         logic            en;
         @(posedge clock);
         if (reset) begin
            m_cyc = 0; m_tick = 1'b0;
            m_d1 = '0; m_d2 = '0;
            m_level = '0; m_press = '0; m_rel = '0;
            for (int i = 0; i < N_CH; i++) begin
               m_run[i] = 0; m_held[i] = 0;
            end
         end else begin
            en    = m_tick;
            samp  = m_d2;
            m_d2  = m_d1;
            m_d1  = raw_in;
            m_cyc = m_cyc + 1;
            m_tick = ((m_cyc % DIV) == 0);
            m_press = '0;
            m_rel   = '0;
            if (en) begin
               for (int i = 0; i < N_CH; i++) begin
                  m_run[i] = (samp[i] != m_level[i]) ? m_run[i] + 1 : 0;
                  if (m_run[i] == STABLE) begin
                     m_run[i]   = 0;
                     m_level[i] = ~m_level[i];
                     m_held[i]  = 0;
                     if (m_level[i]) m_press[i] = 1'b1;
                     else            m_rel[i]   = 1'b1;
                  end else if (m_level[i]) begin
                     if (rpt_en[i]) begin
                        m_held[i] = m_held[i] + 1;
                        if (m_held[i] == RDELAY ||
                            (m_held[i] > RDELAY && ((m_held[i] - RDELAY) % RRATE) == 0))
                           m_press[i] = 1'b1;
                     end else begin
                        m_held[i] = 0;
                     end
                  end
               end
            end
         end
      end
   end

   // Drop all inputs and let every channel fall back to idle.
   task automatic quiesce();
      raw_in = '0;
      rpt_en = '0;
      repeat (60) @(negedge clock);
   endtask

   task automatic test_reset();
      reset = 1'b1; raw_in = '0; rpt_en = '0;
      repeat (3) @(negedge clock);
      n_checks++;
      if ({level, press, release_pulse, tick} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got %b, want 0", {level, press, release_pulse, tick});
      end
      reset = 1'b0;
      for (int k = 1; k <= 35; k++) begin
         @(negedge clock);
         n_checks++;
         if (tick !== ((k % DIV) == 0)) begin
            n_fail++;
            $display("FAIL tick_period cycle %0d: got %b, want %b", k, tick, (k % DIV) == 0);
         end
         n_checks++;
         if ({level, press, release_pulse} !== '0) begin
            n_fail++;
            $display("FAIL reset_quiet cycle %0d: got %b, want 0", k, {level, press, release_pulse});
         end
         n_checks++;
         if ({level, press, release_pulse, tick} !== {m_level, m_press, m_rel, m_tick}) begin
            n_fail++;
            $display("FAIL model_reset: got %b, want %b", {level, press, release_pulse, tick}, {m_level, m_press, m_rel, m_tick});
         end
      end
   endtask

   task automatic test_single_press();
      int   t_press = -1;
      int   n_press = 0;
      int   n_rel   = 0;
      logic prev_lvl;
      rpt_en = '0;
      repeat ($urandom_range(0, 9)) @(negedge clock);
      prev_lvl  = level[0];
      raw_in[0] = 1'b1;
      for (int t = 1; t <= 150; t++) begin
         @(negedge clock);
         n_checks++;
         if ({level, press, release_pulse, tick} !== {m_level, m_press, m_rel, m_tick}) begin
            n_fail++;
            $display("FAIL model_single: got %b, want %b", {level, press, release_pulse, tick}, {m_level, m_press, m_rel, m_tick});
         end
         if (press[0]) begin
            n_press++;
            if (t_press < 0) begin
               t_press = t;
               n_checks++;
               if ({prev_lvl, level[0]} !== 2'b01) begin
                  n_fail++;
                  $display("FAIL press_with_rise: level prev/now %b, want 01", {prev_lvl, level[0]});
               end
            end
         end
         if (release_pulse[0]) n_rel++;
         prev_lvl = level[0];
      end
      n_checks++;
      if (t_press < 1 || t_press > 43) begin
         n_fail++;
         $display("FAIL press_latency: got %0d cycles, want 1..43", t_press);
      end
      n_checks++;
      if (n_press != 1 || n_rel != 0) begin
         n_fail++;
         $display("FAIL single_pulse: got %0d press %0d release, want 1 press 0 release", n_press, n_rel);
      end
      raw_in[0] = 1'b0;
      n_rel = 0;
      for (int t = 1; t <= 60; t++) begin
         @(negedge clock);
         if (release_pulse[0]) begin
            n_rel++;
            n_checks++;
            if (level[0] !== 1'b0 || press[0] !== 1'b0) begin
               n_fail++;
               $display("FAIL release_with_fall: level %b press %b, want 0 0", level[0], press[0]);
            end
         end
      end
      n_checks++;
      if (n_rel != 1 || level[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL single_release: got %0d releases level %b, want 1 and 0", n_rel, level[0]);
      end
   endtask

   task automatic test_bounce();
      int bad = 0;
      repeat ($urandom_range(0, 9)) @(negedge clock);
      for (int rep = 0; rep < 5; rep++) begin
         raw_in[1] = 1'b1;
         for (int c = 0; c < 30; c++) begin
            if (c == 20) raw_in[1] = 1'b0;
            @(negedge clock);
            if ({level[1], press[1], release_pulse[1]} !== 3'b000) bad++;
            n_checks++;
            if ({level, press, release_pulse, tick} !== {m_level, m_press, m_rel, m_tick}) begin
               n_fail++;
               $display("FAIL model_bounce: got %b, want %b", {level, press, release_pulse, tick}, {m_level, m_press, m_rel, m_tick});
            end
         end
      end
      repeat (50) begin
         @(negedge clock);
         if ({level[1], press[1], release_pulse[1]} !== 3'b000) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL bounce_reject: got %0d active cycles on ch1, want 0", bad);
      end
   endtask

   task automatic test_repeat();
      int times [$];
      int t   = 0;
      int rel_t = -1;
      int late_press = 0;
      rpt_en[0] = 1'b1;
      raw_in[0] = 1'b1;
      while (times.size() < 5 && t < 400) begin
         @(negedge clock);
         t++;
         if (press[0]) times.push_back(t);
         n_checks++;
         if ({level, press, release_pulse, tick} !== {m_level, m_press, m_rel, m_tick}) begin
            n_fail++;
            $display("FAIL model_repeat: got %b, want %b", {level, press, release_pulse, tick}, {m_level, m_press, m_rel, m_tick});
         end
      end
      n_checks++;
      if (times.size() != 5) begin
         n_fail++;
         $display("FAIL repeat_count: got %0d presses in %0d cycles, want 5", times.size(), t);
      end else begin
         for (int k = 1; k < 5; k++) begin
            n_checks++;
            if (times[k] - times[k-1] != ((k == 1) ? RDELAY * DIV : RRATE * DIV)) begin
               n_fail++;
               $display("FAIL repeat_gap %0d: got %0d, want %0d", k, times[k] - times[k-1], (k == 1) ? RDELAY * DIV : RRATE * DIV);
            end
         end
      end
      raw_in[0] = 1'b0;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clock);
         if (rel_t >= 0 && press[0]) late_press++;
         if (release_pulse[0]) begin
            n_checks++;
            if (rel_t >= 0 || press[0] !== 1'b0) begin
               n_fail++;
               $display("FAIL repeat_release: extra release or press %b with release", press[0]);
            end
            rel_t = c;
         end
         n_checks++;
         if ({level, press, release_pulse, tick} !== {m_level, m_press, m_rel, m_tick}) begin
            n_fail++;
            $display("FAIL model_repeat_rel: got %b, want %b", {level, press, release_pulse, tick}, {m_level, m_press, m_rel, m_tick});
         end
      end
      n_checks++;
      if (rel_t < 0 || late_press != 0) begin
         n_fail++;
         $display("FAIL repeat_stop: release at %0d, %0d presses after it, want one release and 0 presses", rel_t, late_press);
      end
      rpt_en[0] = 1'b0;
   endtask

   task automatic test_simultaneous();
      int t = 0;
      rpt_en = '0;
      repeat ($urandom_range(0, 9)) @(negedge clock);
      raw_in = 3'b101;
      while (press === 3'b000 && t < 60) begin
         @(negedge clock);
         t++;
      end
      n_checks++;
      if (press !== 3'b101 || level !== 3'b101) begin
         n_fail++;
         $display("FAIL simultaneous_press: press %b level %b after %0d cycles, want 101 101", press, level, t);
      end
      raw_in = 3'b000;
      t = 0;
      while (release_pulse === 3'b000 && t < 60) begin
         @(negedge clock);
         t++;
      end
      n_checks++;
      if (release_pulse !== 3'b101 || level !== 3'b000) begin
         n_fail++;
         $display("FAIL simultaneous_release: release %b level %b, want 101 000", release_pulse, level);
      end
   endtask

   task automatic test_reset_mid_hold();
      int n_p = 0;
      int n_r = 0;
      int t   = 0;
      rpt_en[0] = 1'b1;
      raw_in[0] = 1'b1;
      while (n_p < 2 && t < 300) begin
         @(negedge clock);
         t++;
         if (press[0]) n_p++;
      end
      n_checks++;
      if (n_p != 2) begin
         n_fail++;
         $display("FAIL reach_repeating: got %0d presses, want 2", n_p);
      end
      repeat ($urandom_range(1, 20)) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      n_checks++;
      if ({level, press, release_pulse, tick} !== '0) begin
         n_fail++;
         $display("FAIL mid_hold_reset: got %b, want 0", {level, press, release_pulse, tick});
      end
      n_p = 0;
      for (int c = 1; c <= 120; c++) begin
         @(negedge clock);
         if (press[0]) n_p++;
         if (release_pulse[0]) n_r++;
         n_checks++;
         if ({level, press, release_pulse, tick} !== {m_level, m_press, m_rel, m_tick}) begin
            n_fail++;
            $display("FAIL model_mid_reset: got %b, want %b", {level, press, release_pulse, tick}, {m_level, m_press, m_rel, m_tick});
         end
      end
      n_checks++;
      if (n_p != 1 || n_r != 0 || level[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL re_press: got %0d press %0d release level %b, want 1 0 1", n_p, n_r, level[0]);
      end
   endtask

   task automatic test_random();
      int left = 0;
      for (int c = 0; c < 3000; c++) begin
         if (left == 0) begin
            raw_in = N_CH'($urandom);
            rpt_en = N_CH'($urandom);
            left   = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 200) : $urandom_range(1, 50);
         end
         left--;
         @(negedge clock);
         n_checks++;
         if ({level, press, release_pulse, tick} !== {m_level, m_press, m_rel, m_tick}) begin
            n_fail++;
            $display("FAIL model_random cycle %0d: got %b, want %b", c, {level, press, release_pulse, tick}, {m_level, m_press, m_rel, m_tick});
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_press();
      quiesce();
      test_bounce();
      quiesce();
      test_repeat();
      quiesce();
      test_simultaneous();
      quiesce();
      test_reset_mid_hold();
      quiesce();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
